assertion_monitor: RTL and testbench
====================================

Name: assertion_monitor

Overview:
- Parametrised, synthesizable hardware assertion checker for N independent channels.
- Each channel checks one implication: if `antecedent[i]` is seen on a clock edge, `consequent[i]` must be high exactly DELAY edges later. DELAY=1 is the classic "toggle state implies output" check.
- Violations are turned into observable hardware state: sticky per-channel flags, a one-cycle pulse, a saturating count and a first-failure record with channel and timestamp.
- Sits beside the DUT in simulation and FPGA builds. It observes only and never drives the DUT.

Parameters:
- N_CH, 4, number of checked channels (>=1).
- DELAY, 1, edges between antecedent and consequent sampling (>=1).
- CNT_W, 8, width of the saturating failure counter.
- TS_W, 16, width of the free-running cycle timestamp.
- CH_W, $clog2(N_CH) (minimum 1), derived width of the channel index.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `clear`  in  1  synchronous clear of the reporting state.
- `ch_en`  in  N_CH  per-channel enable, sampled together with antecedent.
- `antecedent`  in  N_CH  trigger condition per channel.
- `consequent`  in  N_CH  required response per channel.
- `fail`  out  N_CH  sticky per-channel failure flag.
- `fail_pulse`  out  N_CH  one-cycle pulse per detected violation.
- `any_fail`  out  1  OR of `fail`, registered.
- `fail_count`  out  CNT_W  saturating total of violations.
- `first_valid`  out  1  high once the first failure has been captured.
- `first_ch`  out  CH_W  channel of the first failure.
- `first_ts`  out  TS_W  timestamp of the first failure.

Behaviour:
- Reset (`reset`=0, async): all outputs 0; obligation pipelines and timestamp cleared.
- Timestamp: `ts` increments every edge from 0 and wraps modulo 2^TS_W. `clear` does not reset it.
- Obligation per channel: edge k samples `ch_en[i] && antecedent[i]`. That bit moves through a DELAY-deep shift register.
  - At edge k+DELAY, if the bit leaving the register is 1 and `consequent[i]`=0, a violation occurs on channel i.
  - Obligations overlap: back-to-back antecedents each create an independent check.
- `ch_en` matters only at antecedent time. In-flight obligations are still checked after `ch_en` drops.
- On a violation at edge k+DELAY, the outputs are registered by that same edge and visible in the following cycle:
  - `fail_pulse[i]`=1 for exactly one cycle.
  - `fail[i]` set, and held until `clear` or reset.
  - `fail_count` += popcount of this edge's violations, saturating at 2^CNT_W-1 (no wrap).
  - If `first_valid`=0: `first_valid`=1, `first_ch` = lowest violating index, `first_ts` = `ts` value at the violation edge. Later failures do not overwrite it.
- `any_fail` is the registered OR of the next-state `fail` vector, so it rises in the same cycle as `fail`.
- `clear`=1 at an edge:
  - Zeroes `fail`, `fail_count` and `first_*`.
  - Does not flush obligations.
  - A violation at the same edge is recorded on top of the cleared state, so the new failure survives the clear.
- Reset mid-operation: pending obligations are discarded; no failure is reported for them.
- Simultaneous violations on several channels: all flags and pulses set; count adds the full popcount; `first_ch` = lowest index.
- No FSM beyond the per-channel delay lines and the first-capture bit (EMPTY -> CAPTURED on first violation; CAPTURED -> EMPTY on `clear` with no concurrent violation).

Decomposition:
- Package `assertion_monitor_pkg`:
  - default parameter constants;
  - `first_state_t` enum {EMPTY, CAPTURED};
  - popcount function;
  - lowest-set-index function.
- Sub-module `obligation_delay_line` (params DELAY; one per channel via generate). Inputs `clk`, `reset`, `trig`; output `due`.
- Top-level holds reporting, saturation and capture logic.

Test Plan:
- Pass and fail, N_CH=4, DELAY=1: antecedent[0]=1 at edge 10, consequent[0]=1 at edge 11 -> no failure. Repeat at edge 20 with consequent[0]=0 at edge 21 -> fail_pulse[0] one cycle, fail=4'b0001, fail_count=1, first_ch=0, first_ts=21.
- Overlap, DELAY=3: antecedent[2] high for edges 5,6,7; consequent[2] low only at edge 9 -> exactly one violation, fail_count=1, first_ts=9.
- Simultaneous violations: channels 1 and 3 fail at the same edge -> fail=4'b1010, fail_count +=2, first_ch=1.
- Saturation, CNT_W=2: five violations -> fail_count stays 3.
- Clear: clear asserted at the same edge as a channel-2 violation -> fail=4'b0100, fail_count=1, first_ch=2.
- Enable and reset:
  - ch_en[0]=0 at antecedent time -> no check.
  - ch_en dropped after antecedent -> check still fires.
  - Async reset with obligations in flight -> all outputs 0 immediately, no late failure afterwards.

Source files
------------

// File: rtl/assertion_monitor_pkg.sv
// Shared constants, capture-state type and vector helpers for the assertion monitor.
package assertion_monitor_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int DELAY_DEF = 1;
  localparam int CNT_W_DEF = 8;
  localparam int TS_W_DEF  = 16;

  // Helpers operate on a fixed-width vector; channel counts above MAX_CH are unsupported.
  localparam int MAX_CH = 64;
  localparam int PC_W   = 7;
  localparam int IDX_W  = 6;

  typedef enum logic {
    EMPTY    = 1'b0,
    CAPTURED = 1'b1
  } first_state_t;

  function automatic logic [PC_W-1:0] popcount(input logic [MAX_CH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_CH; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [MAX_CH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) if (v[i]) idx = IDX_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/obligation_delay_line.sv
// Carries one channel's "consequent is owed" bit forward DELAY edges.
module obligation_delay_line #(
  parameter int DELAY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  output logic due
);

  logic [DELAY-1:0] pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= trig;
      for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign due = pipe[DELAY-1];

endmodule

// File: rtl/assertion_monitor.sv
// N-channel "antecedent implies consequent DELAY edges later" checker with
// sticky flags, pulses, saturating count and first-failure capture.
module assertion_monitor
  import assertion_monitor_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int DELAY = DELAY_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH-1:0]   antecedent,
  input  logic [N_CH-1:0]   consequent,
  output logic [N_CH-1:0]   fail,
  output logic [N_CH-1:0]   fail_pulse,
  output logic              any_fail,
  output logic [CNT_W-1:0]  fail_count,
  output logic              first_valid,
  output logic [CH_W-1:0]   first_ch,
  output logic [TS_W-1:0]   first_ts
);

  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0]   ts;
  logic [N_CH-1:0]   due, viol, fail_n;
  logic [MAX_CH-1:0] viol_w;
  logic [CNT_W-1:0]  cnt_base, cnt_n;
  logic [SUM_W-1:0]  sum;
  first_state_t      first_state;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    obligation_delay_line #(.DELAY(DELAY)) u_dl (
      .clk   (clk),
      .reset (reset),
      .trig  (ch_en[i] & antecedent[i]),
      .due   (due[i])
    );
  end

  assign viol   = due & ~consequent;
  assign viol_w = MAX_CH'(viol);

  // Clear acts first so a violation on the clearing edge lands on the cleared state.
  always_comb begin
    fail_n   = (clear ? '0 : fail) | viol;
    cnt_base = clear ? '0 : fail_count;
    sum      = SUM_W'(cnt_base) + SUM_W'(popcount(viol_w));
    cnt_n    = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts          <= '0;
      fail        <= '0;
      fail_pulse  <= '0;
      any_fail    <= 1'b0;
      fail_count  <= '0;
      first_state <= EMPTY;
      first_ch    <= '0;
      first_ts    <= '0;
    end else begin
      ts         <= ts + TS_W'(1);
      fail       <= fail_n;
      fail_pulse <= viol;
      any_fail   <= |fail_n;
      fail_count <= cnt_n;
      if (|viol && (clear || first_state == EMPTY)) begin
        first_state <= CAPTURED;
        first_ch    <= CH_W'(lowest_idx(viol_w));
        first_ts    <= ts;
      end else if (clear) begin
        first_state <= EMPTY;
        first_ch    <= '0;
        first_ts    <= '0;
      end
    end
  end

  assign first_valid = (first_state == CAPTURED);

endmodule

// File: tb/tb_assertion_monitor.sv
// Bench for assertion_monitor: two configurations (DELAY=1/CNT_W=8, DELAY=3/CNT_W=2)
// share stimulus and are compared every cycle against an edge-history reference model.
module tb_assertion_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] en = 4'hF, ant = 4'h0, cons = 4'hF;

  logic [3:0]  d1_fail, d1_pulse, d3_fail, d3_pulse;
  logic        d1_any, d3_any, d1_fv, d3_fv;
  logic [7:0]  d1_cnt;
  logic [1:0]  d3_cnt;
  logic [1:0]  d1_fch, d3_fch;
  logic [15:0] d1_fts, d3_fts;

  always #5 clk = ~clk;

  assertion_monitor #(.N_CH(4), .DELAY(1), .CNT_W(8), .TS_W(16)) u_d1 (
    .clk(clk), .reset(reset), .clear(clr), .ch_en(en), .antecedent(ant), .consequent(cons),
    .fail(d1_fail), .fail_pulse(d1_pulse), .any_fail(d1_any), .fail_count(d1_cnt),
    .first_valid(d1_fv), .first_ch(d1_fch), .first_ts(d1_fts));

  assertion_monitor #(.N_CH(4), .DELAY(3), .CNT_W(2), .TS_W(16)) u_d3 (
    .clk(clk), .reset(reset), .clear(clr), .ch_en(en), .antecedent(ant), .consequent(cons),
    .fail(d3_fail), .fail_pulse(d3_pulse), .any_fail(d3_any), .fail_count(d3_cnt),
    .first_valid(d3_fv), .first_ch(d3_fch), .first_ts(d3_fts));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: remembers what was triggered at each edge since reset and
  // looks back DL[m] edges to decide whether this edge owes a consequent.
  localparam int DL[2]   = '{1, 3};
  localparam int CMAX[2] = '{255, 3};
  logic [3:0] hist [2][64];
  logic [3:0] m_fail[2], m_pulse[2], mv;
  logic       m_any[2], m_fv[2];
  int         m_cnt[2], m_fch[2], m_fts[2];
  int         edge_n;

  function automatic int lowest(input logic [3:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    edge_n = 0;
    for (int m = 0; m < 2; m++) begin
      m_fail[m] = '0; m_pulse[m] = '0; m_any[m] = 1'b0; m_fv[m] = 1'b0;
      m_cnt[m] = 0; m_fch[m] = 0; m_fts[m] = 0;
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      mv = (edge_n >= DL[m]) ? (hist[m][(edge_n - DL[m]) % 64] & ~cons) : 4'h0;
      hist[m][edge_n % 64] = en & ant;
      if (clr) begin
        m_fail[m] = '0; m_cnt[m] = 0; m_fv[m] = 1'b0; m_fch[m] = 0; m_fts[m] = 0;
      end
      m_fail[m]  = m_fail[m] | mv;
      m_pulse[m] = mv;
      m_cnt[m]   = m_cnt[m] + $countones(mv);
      if (m_cnt[m] > CMAX[m]) m_cnt[m] = CMAX[m];
      if (!m_fv[m] && mv != 4'h0) begin
        m_fv[m] = 1'b1; m_fch[m] = lowest(mv); m_fts[m] = edge_n % 65536;
      end
      m_any[m] = |m_fail[m];
    end
    edge_n++;
  endtask

  task automatic cmp_inst(input int m, input string p, input logic [3:0] f, pl, input logic an,
                          input logic [31:0] cn, input logic fv, input logic [31:0] fc, ft);
    chk({p, ".fail"}, 32'(f), 32'(m_fail[m]));
    chk({p, ".pulse"}, 32'(pl), 32'(m_pulse[m]));
    chk({p, ".any"}, 32'(an), 32'(m_any[m]));
    chk({p, ".cnt"}, cn, m_cnt[m]);
    chk({p, ".fv"}, 32'(fv), 32'(m_fv[m]));
    chk({p, ".fch"}, fc, m_fch[m]);
    chk({p, ".fts"}, ft, m_fts[m]);
  endtask

  task automatic check_all();
    cmp_inst(0, "d1", d1_fail, d1_pulse, d1_any, 32'(d1_cnt), d1_fv, 32'(d1_fch), 32'(d1_fts));
    cmp_inst(1, "d3", d3_fail, d3_pulse, d3_any, 32'(d3_cnt), d3_fv, 32'(d3_fch), 32'(d3_fts));
  endtask

  // Inputs are driven at the falling edge, sampled at the next rising edge, checked at the falling edge.
  task automatic step(input logic [3:0] e_, a_, c_, input logic cl_);
    en = e_; ant = a_; cons = c_; clr = cl_;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic apply_reset();
    en = 4'hF; ant = 4'h0; cons = 4'hF; clr = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all();
    chk("rst.any", 32'(d1_any | d3_any), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;

    // Pass then fail on channel 0 with DELAY=1.
    for (int e = 0; e < 24; e++) begin
      step(4'hF, (e == 10 || e == 20) ? 4'b0001 : 4'h0, (e == 21) ? 4'b1110 : 4'hF, 1'b0);
      if (e == 11) chk("s1.pass", 32'(d1_fail), 0);
      if (e == 21) begin
        chk("s1.pulse", 32'(d1_pulse), 1); chk("s1.fail", 32'(d1_fail), 1);
        chk("s1.cnt", 32'(d1_cnt), 1); chk("s1.fch", 32'(d1_fch), 0);
        chk("s1.fts", 32'(d1_fts), 21);
      end
      if (e == 22) chk("s1.pulse_off", 32'(d1_pulse), 0);
    end

    // Overlapping obligations with DELAY=3.
    apply_reset();
    for (int e = 0; e < 12; e++) begin
      step(4'hF, (e >= 5 && e <= 7) ? 4'b0100 : 4'h0, (e == 9) ? 4'b1011 : 4'hF, 1'b0);
      if (e == 11) begin
        chk("s2.cnt", 32'(d3_cnt), 1); chk("s2.fts", 32'(d3_fts), 9);
        chk("s2.fail", 32'(d3_fail), 4);
      end
    end

    // Simultaneous violations on channels 1 and 3.
    apply_reset();
    for (int e = 0; e < 6; e++) begin
      step(4'hF, (e == 3) ? 4'b1010 : 4'h0, (e == 4) ? 4'b0101 : 4'hF, 1'b0);
      if (e == 4) begin
        chk("s3.fail", 32'(d1_fail), 10); chk("s3.cnt", 32'(d1_cnt), 2);
        chk("s3.fch", 32'(d1_fch), 1);
      end
    end

    // Saturation of the 2-bit counter.
    apply_reset();
    for (int e = 0; e < 9; e++) begin
      step(4'hF, (e <= 4) ? 4'b0001 : 4'h0, (e >= 3 && e <= 7) ? 4'b1110 : 4'hF, 1'b0);
      if (e == 8) begin
        chk("s4.sat", 32'(d3_cnt), 3); chk("s4.cnt8", 32'(d1_cnt), 3);
      end
    end

    // Clear on the same edge as a channel-2 violation.
    apply_reset();
    for (int e = 0; e < 9; e++) begin
      step(4'hF, (e == 2) ? 4'b0001 : (e == 6) ? 4'b0100 : 4'h0,
           (e == 3) ? 4'b1110 : (e == 7) ? 4'b1011 : 4'hF, e == 7);
      if (e == 7) begin
        chk("s5.fail", 32'(d1_fail), 4); chk("s5.cnt", 32'(d1_cnt), 1);
        chk("s5.fch", 32'(d1_fch), 2); chk("s5.fts", 32'(d1_fts), 7);
      end
    end

    // Enable only matters at antecedent time.
    apply_reset();
    for (int e = 0; e < 8; e++) begin
      step((e == 2 || e == 6) ? 4'b1110 : 4'hF, (e == 2 || e == 5) ? 4'b0001 : 4'h0,
           (e == 3 || e == 6) ? 4'b1110 : 4'hF, 1'b0);
      if (e == 3) chk("s6.gated", 32'(d1_fail), 0);
      if (e == 6) begin
        chk("s6.fail", 32'(d1_fail), 1); chk("s6.fts", 32'(d1_fts), 6);
      end
    end

    // Async reset with obligations in flight: nothing reported afterwards.
    apply_reset();
    for (int e = 0; e < 4; e++) step(4'hF, (e == 2) ? 4'hF : 4'h0, 4'hF, 1'b0);
    apply_reset();
    for (int e = 0; e < 6; e++) step(4'hF, 4'h0, 4'h0, 1'b0);
    chk("s7.d3fail", 32'(d3_fail), 0);
    chk("s7.d1cnt", 32'(d1_cnt), 0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) apply_reset();
      step(4'($urandom | $urandom), 4'($urandom & $urandom), 4'($urandom | $urandom),
           $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
